// File: rtl/t01_audio_pkg.sv
// Shared types, default timing constants and width helpers for the game audio output stage.
package t01_audio_pkg;

    typedef enum logic [1:0] {
        SFX_NONE,
        SFX_CLEAR,
        SFX_DROP,
        SFX_ROTATE
    } sfx_t;

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    localparam int DEF_TICK_DIV    = 25000;
    localparam int DEF_CLEAR_HALF  = 14204;
    localparam int DEF_DROP_HALF   = 56818;
    localparam int DEF_ROTATE_HALF = 28409;
    localparam int DEF_CLEAR_MS    = 240;
    localparam int DEF_DROP_MS     = 60;
    localparam int DEF_ROTATE_MS   = 30;
    localparam int DEF_PWM_BITS    = 4;

    // bits needed to hold the values 0..max_val
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/t01_pwm_dac.sv
// 1-bit PWM DAC: free-running duty counter compared against volume, gated by mute, registered.
module t01_pwm_dac
    import t01_audio_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src,
    input  logic [PWM_BITS-1:0] volume,
    input  logic                mute,
    output logic                audio_pwm
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                audio_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            audio_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            audio_q   <= src & (pwm_cnt_q < volume) & ~mute;
        end
    end

    assign audio_pwm = audio_q;

endmodule

// File: rtl/t01_sfx_mixer.sv
// Sound-effect sequencer: latches game events, plays prioritised effect tones that fully
// duck the incoming music, and feeds the selected source to the PWM output stage.
module t01_sfx_mixer
    import t01_audio_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int CLEAR_HALF  = DEF_CLEAR_HALF,
    parameter int DROP_HALF   = DEF_DROP_HALF,
    parameter int ROTATE_HALF = DEF_ROTATE_HALF,
    parameter int CLEAR_MS    = DEF_CLEAR_MS,
    parameter int DROP_MS     = DEF_DROP_MS,
    parameter int ROTATE_MS   = DEF_ROTATE_MS,
    parameter int PWM_BITS    = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                music_in,
    input  logic                sfx_clear,
    input  logic                sfx_drop,
    input  logic                sfx_rotate,
    input  logic                mute,
    input  logic [PWM_BITS-1:0] volume,
    output logic                audio_pwm,
    output logic                sfx_busy
);

    localparam int TONE_W = cnt_w(max3(CLEAR_HALF, DROP_HALF, ROTATE_HALF) - 1);
    localparam int TICK_W = cnt_w(TICK_DIV - 1);
    localparam int DUR_W  = cnt_w(max3(CLEAR_MS, DROP_MS, ROTATE_MS));

    state_t              state_q, state_d;
    sfx_t                sfx_q, sfx_d;
    logic [2:0]          pend_q, pend_d;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                tone_q, tone_d;

    logic [2:0]          evt;
    sfx_t                cur_sfx, cand_sfx, load_sfx;
    logic                retrig, tick, src;
    logic [TONE_W-1:0]   half_m1;

    function automatic logic [2:0] sfx_bit(input sfx_t k);
        case (k)
            SFX_CLEAR:  return 3'b001;
            SFX_DROP:   return 3'b010;
            SFX_ROTATE: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    // pending events allowed to start on top of effect k (none playing -> any)
    function automatic logic [2:0] above_mask(input sfx_t k);
        case (k)
            SFX_CLEAR:  return 3'b000;
            SFX_DROP:   return 3'b001;
            SFX_ROTATE: return 3'b011;
            default:    return 3'b111;
        endcase
    endfunction

    function automatic sfx_t pick(input logic [2:0] m);
        if (m[0]) return SFX_CLEAR;
        if (m[1]) return SFX_DROP;
        if (m[2]) return SFX_ROTATE;
        return SFX_NONE;
    endfunction

    function automatic logic [DUR_W-1:0] dur_of(input sfx_t k);
        case (k)
            SFX_CLEAR:  return DUR_W'(CLEAR_MS);
            SFX_DROP:   return DUR_W'(DROP_MS);
            SFX_ROTATE: return DUR_W'(ROTATE_MS);
            default:    return '0;
        endcase
    endfunction

    // clear jumps an octave up for the second half of its envelope
    function automatic logic [TONE_W-1:0] half_m1_of(input sfx_t k, input logic [DUR_W-1:0] d);
        case (k)
            SFX_CLEAR:  return (d <= DUR_W'(CLEAR_MS / 2)) ? TONE_W'(CLEAR_HALF / 2 - 1)
                                                         : TONE_W'(CLEAR_HALF - 1);
            SFX_DROP:   return TONE_W'(DROP_HALF - 1);
            SFX_ROTATE: return TONE_W'(ROTATE_HALF - 1);
            default:    return '0;
        endcase
    endfunction

    assign evt      = {sfx_rotate, sfx_drop, sfx_clear};
    assign cur_sfx  = (state_q == PLAY) ? sfx_q : SFX_NONE;
    assign cand_sfx = pick(pend_q & above_mask(cur_sfx));
    assign retrig   = (state_q == PLAY) && |(evt & sfx_bit(sfx_q));
    assign load_sfx = (cand_sfx != SFX_NONE) ? cand_sfx : sfx_q;
    assign tick     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign half_m1  = half_m1_of(sfx_q, dur_q);

    always_comb begin
        state_d    = state_q;
        sfx_d      = sfx_q;
        tone_cnt_d = tone_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_d      = dur_q;
        tone_d     = tone_q;
        // a pulse for the effect already playing is a retrigger, never a pending request
        pend_d     = (pend_q & ~sfx_bit(cand_sfx)) | (evt & ~sfx_bit(cur_sfx));

        if (cand_sfx != SFX_NONE || retrig) begin
            state_d    = PLAY;
            sfx_d      = load_sfx;
            tone_cnt_d = '0;
            tick_cnt_d = '0;
            dur_d      = dur_of(load_sfx);
            tone_d     = 1'b1;
        end else if (state_q == PLAY) begin
            if (tone_cnt_q == half_m1) begin
                tone_cnt_d = '0;
                tone_d     = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
            end
            if (tick) begin
                tick_cnt_d = '0;
                dur_d      = dur_q - DUR_W'(1);
                if (dur_q == DUR_W'(1)) begin
                    state_d = IDLE;
                end
                if (sfx_q == SFX_CLEAR && dur_q == DUR_W'(CLEAR_MS / 2 + 1)) begin
                    tone_cnt_d = '0;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sfx_q      <= SFX_NONE;
            pend_q     <= '0;
            tone_cnt_q <= '0;
            tick_cnt_q <= '0;
            dur_q      <= '0;
            tone_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sfx_q      <= sfx_d;
            pend_q     <= pend_d;
            tone_cnt_q <= tone_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_q      <= dur_d;
            tone_q     <= tone_d;
        end
    end

    assign sfx_busy = (state_q == PLAY);
    assign src      = (state_q == PLAY) ? tone_q : music_in;

    t01_pwm_dac #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_dac (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .volume    (volume),
        .mute      (mute),
        .audio_pwm (audio_pwm)
    );

endmodule

// File: doc/t01_sfx_mixer.md
Name: t01_sfx_mixer

Overview:
Audio output stage directly downstream of the t01_musicman tone generator. Consumes its 1-bit square_out as music_in and plays short game sound effects on event pulses (line clear, piece drop, rotate). Effects duck the music while they play. Mixes the result into a volume-scaled, mutable 1-bit PWM stream that drives the board speaker pin.

Parameters:
TICK_DIV, 25000, clk cycles per 1 ms envelope tick
CLEAR_HALF, 14204, clear-effect tone half-period in cycles (880 Hz @25 MHz)
DROP_HALF, 56818, drop-effect half-period (220 Hz)
ROTATE_HALF, 28409, rotate-effect half-period (440 Hz)
CLEAR_MS, 240, clear-effect duration in ticks
DROP_MS, 60, drop-effect duration in ticks
ROTATE_MS, 30, rotate-effect duration in ticks
PWM_BITS, 4, PWM counter / volume width

Ports:
clk  in  1  system clock
rst  in  1  reset
music_in  in  1  square_out from t01_musicman
sfx_clear  in  1  one-cycle pulse: lines cleared
sfx_drop  in  1  one-cycle pulse: piece landed
sfx_rotate  in  1  one-cycle pulse: piece rotated
mute  in  1  1 = force output low
volume  in  PWM_BITS  duty scale, 0 = silent
audio_pwm  out  1  registered PWM speaker output
sfx_busy  out  1  high while an effect plays

Interface: already decided. One clock, clk. Reset rst is asynchronous and active-high.

Behaviour:
- Reset clears all state: pending bits 0, state IDLE, tone/tick/duration/PWM counters 0, audio_pwm 0, sfx_busy 0. Reset mid-effect abandons the effect; nothing resumes.
- Event capture: each pulse sets its pending bit at the next edge. A pulse arriving while its bit is already set is absorbed; there is no counting.
- Priority: clear > drop > rotate.
- FSM states IDLE and PLAY:
  - IDLE with any pending bit set: select the highest priority effect, clear its pending bit, load half-period and duration, reset the tone and tick counters, set tone=1, enter PLAY.
  - Pulse sampled at edge of cycle N: pending in N+1, PLAY and sfx_busy=1 in N+2.
- In PLAY:
  - Tone counter increments each cycle. At half-1 it wraps to 0 and tone toggles.
  - Tick counter wraps at TICK_DIV-1 and emits a 1-cycle tick. Each tick decrements duration.
  - When a tick takes duration from 1 to 0, go to IDLE. Total play length is exactly MS*TICK_DIV cycles.
  - If another effect is pending at that point, it starts on the next IDLE cycle, which gives a 1-cycle gap.
- Clear effect is two-tone: while duration <= CLEAR_MS>>1 it uses half-period CLEAR_HALF>>1 (octave up). The tone counter resets at the switch.
- Preemption: a strictly higher-priority event pending during PLAY aborts the current effect at the next edge and loads the new one. The aborted effect is dropped, not re-queued.
- Retrigger: the same effect's pulse during its own play restarts duration and counters at the next edge. Its pending bit is not set.
- Lower-priority pulses during PLAY stay pending.
- Source selection: src = (state==PLAY) ? tone : music_in. Music is fully ducked during effects.
- PWM:
  - Free-running PWM_BITS counter.
  - audio_pwm <= src & (pwm_cnt < volume) & ~mute, registered, so src/mute changes appear 1 cycle later.
  - volume=0 gives a constant 0. volume=15 gives 15/16 duty while src=1.
- mute affects only the output. FSM and event capture continue.
- sfx_busy = (state==PLAY), decoded from the state register.
- All counters are sized by $clog2 of their maximum. No counter may overflow at the default parameters.

Decomposition:
- t01_audio_pkg holds:
  - sfx_t enum: SFX_NONE, SFX_CLEAR, SFX_DROP, SFX_ROTATE
  - state_t enum: IDLE, PLAY
  - default half-period and duration constants
- One sub-module, t01_pwm_dac: PWM counter, compare, mute gating and output register. Inputs src, volume, mute; output audio_pwm.
- Effect FSM, pending bits and tone/envelope counters stay in t01_sfx_mixer.

Test Plan:
Sim parameters: TICK_DIV=10, CLEAR_HALF=8, DROP_HALF=20, ROTATE_HALF=4, CLEAR_MS=8, DROP_MS=4, ROTATE_MS=2.
1. Reset, volume=15, mute=0, music_in=1, no events -> audio_pwm is high 15 of every 16 cycles. sfx_busy=0 throughout.
2. sfx_rotate pulse at cycle N -> sfx_busy rises at N+2 and falls after exactly 20 cycles. Tone toggles every 4 cycles. music_in is ignored during play.
3. sfx_clear -> 40 cycles with half-period 8, then 40 cycles with half-period 4. sfx_busy is high 80 cycles total.
4. sfx_drop, then sfx_clear 5 cycles later -> drop aborted, clear starts 1 edge later. Drop never replays and there is no pending residue.
5. sfx_clear and sfx_rotate in the same cycle -> clear plays 80 cycles, 1 idle cycle, then rotate plays 20 cycles.
6. mute=1 during a clear, and volume=0 with mute=0 -> audio_pwm constant 0 in both cases, while sfx_busy still follows the 80-cycle timing. rst asserted mid-effect -> busy and audio_pwm go 0 immediately (async) and stay idle after release.
